// File: rtl/bcd_entry_loader.sv
// Debounces enter/commit/cancel buttons, collects up to DIGITS BCD digits, converts
// them to binary by iterative x10 accumulate and issues a one-cycle load pulse.
module bcd_entry_loader #(
  parameter int DIGITS             = 6,
  parameter int DATA_OUT_SIZE      = 20,
  parameter int DEBOUNCE_THRESHOLD = 10
) (
  input  logic                     clk,
  input  logic                     rst_btn,
  input  logic [3:0]               digit_in,
  input  logic                     enter_btn,
  input  logic                     commit_btn,
  input  logic                     cancel_btn,
  output logic [DATA_OUT_SIZE-1:0] data_out,
  output logic                     load,
  output logic                     busy,
  output logic                     overflow,
  output logic                     digit_err,
  output logic [2:0]               digit_count,
  output logic [4*DIGITS-1:0]      bcd_buf
);

  localparam int BW = 4 * DIGITS;
  // Accumulator must hold 999999 even when data_out is narrow.
  localparam int AW = (DATA_OUT_SIZE + 4 > 20) ? DATA_OUT_SIZE + 4 : 20;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(DEBOUNCE_THRESHOLD + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;

  // Button index: 0 = enter, 1 = commit, 2 = cancel.
  logic [2:0]    raw;
  logic [2:0]    sync1_q, sync2_q, stable_q, ev_q;
  logic [CW-1:0] cnt_q [3];

  assign raw = {cancel_btn, commit_btn, enter_btn};

  always_ff @(posedge clk) begin
    if (rst_btn) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      ev_q     <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        ev_q[i] <= 1'b0;
        if (sync2_q[i] != stable_q[i]) begin
          if (cnt_q[i] == CW'(DEBOUNCE_THRESHOLD - 1)) begin
            stable_q[i] <= sync2_q[i];
            ev_q[i]     <= sync2_q[i];
            cnt_q[i]    <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CW'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  state_t                   state_q;
  logic [AW-1:0]            acc_q, acc_d;
  logic [IW-1:0]            idx_q;
  logic [DATA_OUT_SIZE-1:0] data_q;
  logic                     load_q, busy_q, ovf_q, err_q;
  logic [2:0]               cnt_dig_q;
  logic [BW-1:0]            buf_q;
  logic [3:0]               cur_digit;
  logic                     sat;

  always_comb begin
    cur_digit = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) cur_digit = buf_q[4*k +: 4];
    end
  end

  assign acc_d = (acc_q << 3) + (acc_q << 1) + AW'(cur_digit);
  assign sat   = |acc_d[AW-1:DATA_OUT_SIZE];

  always_ff @(posedge clk) begin
    if (rst_btn) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_dig_q <= '0;
      buf_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ev_q[2]) begin
            buf_q     <= '0;
            cnt_dig_q <= '0;
            err_q     <= 1'b0;
          end else if (ev_q[1]) begin
            if (cnt_dig_q != 3'd0) begin
              acc_q   <= '0;
              idx_q   <= IW'(DIGITS - 1);
              ovf_q   <= 1'b0;
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= S_CONVERT;
            end
          end else if (ev_q[0]) begin
            if (digit_in > 4'd9) begin
              err_q <= 1'b1;
            end else if (cnt_dig_q != 3'(DIGITS)) begin
              buf_q     <= BW'({buf_q, digit_in});
              cnt_dig_q <= cnt_dig_q + 3'd1;
            end
          end
        end
        S_CONVERT: begin
          acc_q <= acc_d;
          if (idx_q == '0) begin
            // Last digit folded in: publish the result so load and data coincide.
            data_q    <= sat ? '1 : acc_d[DATA_OUT_SIZE-1:0];
            ovf_q     <= sat;
            load_q    <= 1'b1;
            buf_q     <= '0;
            cnt_dig_q <= '0;
            state_q   <= S_DONE;
          end else begin
            idx_q <= idx_q - IW'(1);
          end
        end
        S_DONE: begin
          load_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_out    = data_q;
  assign load        = load_q;
  assign busy        = busy_q;
  assign overflow    = ovf_q;
  assign digit_err   = err_q;
  assign digit_count = cnt_dig_q;
  assign bcd_buf     = buf_q;

endmodule

// File: tb/tb_bcd_entry_loader.sv
// Bench: two loaders (20-bit and 6-bit data_out) share all inputs; an entry-level
// model predicts the settled outputs of both after every button press.
module tb_bcd_entry_loader;

  localparam int DIGITS = 6;
  localparam int THR    = 10;
  localparam int HOLD   = THR + 8;

  logic        clk = 1'b0;
  logic        rst_btn;
  logic [3:0]  digit_in;
  logic        enter_btn, commit_btn, cancel_btn;

  logic [19:0] a_data;
  logic        a_load, a_busy, a_ovf, a_err;
  logic [2:0]  a_cnt;
  logic [23:0] a_buf;
  logic [5:0]  b_data;
  logic        b_load, b_busy, b_ovf, b_err;
  logic [2:0]  b_cnt;
  logic [23:0] b_buf;

  always #5 clk = ~clk;

  bcd_entry_loader #(.DIGITS(DIGITS), .DATA_OUT_SIZE(20), .DEBOUNCE_THRESHOLD(THR)) dut_a (
    .clk(clk), .rst_btn(rst_btn), .digit_in(digit_in), .enter_btn(enter_btn),
    .commit_btn(commit_btn), .cancel_btn(cancel_btn), .data_out(a_data), .load(a_load),
    .busy(a_busy), .overflow(a_ovf), .digit_err(a_err), .digit_count(a_cnt), .bcd_buf(a_buf));

  bcd_entry_loader #(.DIGITS(DIGITS), .DATA_OUT_SIZE(6), .DEBOUNCE_THRESHOLD(THR)) dut_b (
    .clk(clk), .rst_btn(rst_btn), .digit_in(digit_in), .enter_btn(enter_btn),
    .commit_btn(commit_btn), .cancel_btn(cancel_btn), .data_out(b_data), .load(b_load),
    .busy(b_busy), .overflow(b_ovf), .digit_err(b_err), .digit_count(b_cnt), .bcd_buf(b_buf));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Entry-level model: digits as a list, value by decimal arithmetic.
  int     mq[$];
  bit     m_err;
  longint m_d20, m_d6;
  bit     m_o20, m_o6;

  function automatic longint exp_buf();
    longint b = 0;
    foreach (mq[i]) b = (b << 4) | longint'(mq[i]);
    return b;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_err = 0; m_d20 = 0; m_d6 = 0; m_o20 = 0; m_o6 = 0;
  endtask

  task automatic model_apply(input bit c, input bit m, input bit e, input int d);
    longint v;
    if (c) begin
      mq.delete(); m_err = 0;
    end else if (m) begin
      if (mq.size() != 0) begin
        v = 0;
        foreach (mq[i]) v = v * 10 + mq[i];
        m_o20 = (v > 1048575); m_d20 = m_o20 ? 1048575 : v;
        m_o6  = (v > 63);      m_d6  = m_o6  ? 63 : v;
        m_err = 0;
        mq.delete();
      end
    end else if (e) begin
      if (d > 9) m_err = 1;
      else if (mq.size() < DIGITS) mq.push_back(d);
    end
  endtask

  // Settled-state compare against the model.
  bit chk_en = 0;
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("a_data", a_data, m_d20);   chk("b_data", b_data, m_d6);
      chk("a_ovf", a_ovf, m_o20);     chk("b_ovf", b_ovf, m_o6);
      chk("a_err", a_err, m_err);     chk("b_err", b_err, m_err);
      chk("a_count", a_cnt, mq.size()); chk("b_count", b_cnt, mq.size());
      chk("a_buf", a_buf, exp_buf()); chk("b_buf", b_buf, exp_buf());
      chk("a_busy", a_busy, 0);       chk("b_busy", b_busy, 0);
      chk("a_load", a_load, 0);       chk("b_load", b_load, 0);
    end
  end

  // Load/busy monitors: pulse count, data at load, busy run length.
  int     a_loads = 0, b_loads = 0, a_brun = 0, b_brun = 0;
  int     a_lrun = 0, b_lrun = 0, a_blen = 0, b_blen = 0;
  longint a_ldat = 0, b_ldat = 0;
  always @(posedge clk) begin
    #1;
    if (a_busy) a_brun++; else begin if (a_brun != 0) a_blen = a_brun; a_brun = 0; end
    if (b_busy) b_brun++; else begin if (b_brun != 0) b_blen = b_brun; b_brun = 0; end
    if (a_load) begin a_loads++; a_lrun = a_brun; a_ldat = a_data; end
    if (b_load) begin b_loads++; b_lrun = b_brun; b_ldat = b_data; end
  end

  task automatic settle();
    chk_en = 1;
    repeat (3) @(negedge clk);
    chk_en = 0;
  endtask

  task automatic press(input bit c, input bit m, input bit e, input int d, input string nm);
    int la, lb;
    bit expl;
    la = a_loads; lb = b_loads;
    expl = m && !c && (mq.size() != 0);
    @(negedge clk);
    cancel_btn = c; commit_btn = m; enter_btn = e; digit_in = 4'(d);
    repeat (HOLD) @(negedge clk);
    cancel_btn = 0; commit_btn = 0; enter_btn = 0;
    repeat (HOLD) @(negedge clk);
    model_apply(c, m, e, d);
    chk({nm, "_loads_a"}, a_loads - la, expl ? 1 : 0);
    chk({nm, "_loads_b"}, b_loads - lb, expl ? 1 : 0);
    if (expl) begin
      chk({nm, "_ldat_a"}, a_ldat, m_d20);
      chk({nm, "_ldat_b"}, b_ldat, m_d6);
      chk({nm, "_load_at_busy_end"}, a_lrun, DIGITS + 1);
      chk({nm, "_busy_len"}, a_blen, DIGITS + 1);
      chk({nm, "_busy_len_b"}, b_blen, DIGITS + 1);
    end
    settle();
  endtask

  task automatic do_reset(input int cyc);
    @(negedge clk);
    rst_btn = 1;
    cancel_btn = 0; commit_btn = 0; enter_btn = 0;
    repeat (cyc) @(negedge clk);
    rst_btn = 0;
    model_reset();
  endtask

  initial begin
    int la, w;
    rst_btn = 1; digit_in = 0; enter_btn = 0; commit_btn = 0; cancel_btn = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_btn = 0;
    settle();

    // Reset while idle with a digit held
    press(0, 0, 1, 3, "t1_enter");
    chk("t1_pre_count", a_cnt, 1);
    do_reset(3);
    settle();
    chk("t1_count_zero", a_cnt, 0);
    chk("t1_buf_zero", a_buf, 0);

    // Bouncing enter: only one digit lands
    @(negedge clk);
    digit_in = 4'd4;
    for (int i = 0; i < 40; i++) begin
      enter_btn = ((i / 3) % 2 == 0);
      @(negedge clk);
    end
    enter_btn = 1;
    repeat (2 * THR) @(negedge clk);
    enter_btn = 0;
    repeat (HOLD) @(negedge clk);
    model_apply(0, 0, 1, 4);
    settle();
    chk("t2_one_digit", a_cnt, 1);
    chk("t2_buf", a_buf, 'h4);

    // Enter 2,5 and commit
    press(1, 0, 0, 0, "t3_cancel");
    press(0, 0, 1, 2, "t3_e2");
    press(0, 0, 1, 5, "t3_e5");
    chk("t3_buf_lit", a_buf, 'h25);
    press(0, 1, 0, 0, "t3_commit");
    chk("t3_data_lit", a_data, 25);
    chk("t3_ovf_lit", a_ovf, 0);
    chk("t3_buf_cleared", a_buf, 0);

    // Saturation on the 6-bit instance, then cleared by the next commit
    press(0, 0, 1, 1, "t4_e1");
    press(0, 0, 1, 2, "t4_e2");
    press(0, 0, 1, 3, "t4_e3");
    press(0, 1, 0, 0, "t4_commit");
    chk("t4_b_sat_lit", b_data, 63);
    chk("t4_b_ovf_lit", b_ovf, 1);
    chk("t4_a_data_lit", a_data, 123);
    press(0, 0, 1, 9, "t4_e9");
    press(0, 1, 0, 0, "t4_commit2");
    chk("t4_b_data9_lit", b_data, 9);
    chk("t4_b_ovf_clr_lit", b_ovf, 0);

    // Buffer full, bad digit, cancel
    for (int d = 1; d <= 7; d++) press(0, 0, 1, d, "t5_enter");
    chk("t5_count_lit", a_cnt, 6);
    chk("t5_buf_lit", a_buf, 'h123456);
    press(0, 0, 1, 12, "t5_bad");
    chk("t5_err_lit", a_err, 1);
    chk("t5_buf_kept", a_buf, 'h123456);
    press(1, 0, 0, 0, "t5_cancel");
    chk("t5_err_clr", a_err, 0);
    chk("t5_buf_clr", a_buf, 0);

    // Empty commit, reset during conversion, commit+cancel together
    press(0, 1, 0, 0, "t6_empty_commit");
    press(0, 0, 1, 9, "t6_e9");
    la = a_loads;
    @(negedge clk);
    commit_btn = 1;
    w = 0;
    while (!a_busy && w < 40) begin @(negedge clk); w++; end
    chk("t6_busy_seen", a_busy, 1);
    repeat (2) @(negedge clk);
    do_reset(2);
    repeat (HOLD) @(negedge clk);
    chk("t6_no_load_after_rst", a_loads - la, 0);
    settle();
    press(0, 0, 1, 7, "t6_e7");
    press(1, 1, 0, 0, "t6_commit_cancel");
    chk("t6_cc_buf", a_buf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
